aes_inv_cipher_iter: RTL and testbench
======================================

AES_INV_CIPHER_ITER -- requirements
Module: aes_inv_cipher_iter

Interface
REQ-001 Parameter Nk, default 4, key length in 32-bit words; legal values are 4, 6 and 8.
REQ-002 Parameter Nr, default Nk+6, number of rounds.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port k_sch  input  [0:Nr] x 128  round-key schedule from aes_key_expand; entry i is round key i.
REQ-006 Port load  input  1  start request, sampled with ct.
REQ-007 Port ct  input  128  ciphertext block; byte 0 = bits [127:120], column-major per FIPS-197.
REQ-008 Port ready  output  1  block can accept load this cycle.
REQ-009 Port pt  output  128  recovered plaintext, same byte order as ct.
REQ-010 Port valid  output  1  one-cycle pulse; pt is correct in that cycle.

Function
REQ-011 The FSM SHALL have states IDLE, ROUND, FINAL and DONE.
REQ-012 ready SHALL be 1 in IDLE and DONE and 0 in ROUND and FINAL.
REQ-013 When load=1 and ready=1, the block SHALL register state = ct XOR k_sch[Nr], set the round counter r = Nr-1 and enter ROUND.
REQ-014 Each ROUND cycle SHALL apply InvShiftRows, InvSubBytes, AddRoundKey(k_sch[r]) and InvMixColumns, then decrement r.
REQ-015 ROUND SHALL go to FINAL after the cycle with r=1.
REQ-016 FINAL SHALL apply InvShiftRows, InvSubBytes and AddRoundKey(k_sch[0]) with no InvMixColumns, write the result to pt, and enter DONE.
REQ-017 valid SHALL be 1 in exactly the first cycle in DONE.
REQ-018 Latency from the load-accept edge to valid=1 SHALL be Nr+1 cycles: 11, 13 or 15.
REQ-019 pt SHALL hold its value until the next FINAL completes.
REQ-020 DONE SHALL fall to IDLE after one cycle if no load is present.
REQ-021 load while ready=0 SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-022 load in a DONE cycle SHALL be accepted, giving a back-to-back throughput of one block per Nr+1 cycles.
REQ-023 k_sch SHALL be held stable by the source from load accept until valid; the block does not register the schedule.
REQ-024 All GF(2^8) arithmetic SHALL use the polynomial x^8+x^4+x^3+x+1; the round counter width SHALL be 4 bits.
REQ-025 An Nk value outside {4,6,8} SHALL cause an elaboration-time error.

Reset
REQ-026 While rst=1: state=IDLE, r=0, pt=0, valid=0, ready=1, and the internal state register is 0.
REQ-027 rst asserted mid-operation SHALL abort the operation immediately with no valid pulse.
REQ-028 The first load after rst is released SHALL be accepted normally.

Structure
REQ-029 Package aes_pkg SHALL hold the inverse S-box table, the xtime/gmul functions and the 128-bit state typedef, shared with the encrypt path.
REQ-030 Sub-module aes_inv_round SHALL be purely combinational, take state, round key and a last_round flag, and be instantiated once.
REQ-031 The top SHALL hold only the FSM, the counter, the state register and the output register.

Verification
REQ-032 Nk=4, FIPS-197 C.1 key 000102..0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, valid exactly 11 cycles after load.
REQ-033 Nk=6, key 000102..17, ct dda97ca4864cdfe06eaf70a0ec0d7191 -> same pt, valid at cycle 13; Nk=8, key 000102..1f, ct 8ea2b7ca516745bfeafc49904b496089 -> same pt, valid at cycle 15.
REQ-034 Back-to-back: second load asserted in the DONE cycle -> second valid exactly 11 cycles later; pt unchanged between the two valid pulses.
REQ-035 load pulsed at cycles 3 and 7 after an accepted load (Nk=4) -> ignored; a single valid at cycle 11 with the correct pt.
REQ-036 rst pulsed at cycle 5 of an operation -> no valid, pt=0, ready=1; a new load then yields the correct pt at cycle 11.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES definitions: 128-bit state type, inverse S-box
//                table and GF(2^8) helpers (x^8+x^4+x^3+x+1).
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

   typedef logic [127:0] aes_state_t;

   localparam logic [7:0] c_inv_sbox [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // Multiply by x modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // General GF(2^8) product by shift-and-add.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return c_inv_sbox[b];
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_round.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_round
//  Description : One combinational AES inverse round: InvShiftRows,
//                InvSubBytes, AddRoundKey and (unless last) InvMixColumns.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_inv_round
   import aes_pkg::*;
(
   input  aes_state_t i_state,
   input  aes_state_t i_round_key,
   input  logic       i_last_round,
   output aes_state_t o_state
);

   aes_state_t w_subbed;
   aes_state_t w_keyed;
   aes_state_t w_mixed;

   // Byte (row r, column c) sits at index 4c+r; row r rotates right by r.
   always_comb begin
      w_subbed = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            w_subbed[127-8*(4*c+r) -: 8] = inv_sbox(i_state[127-8*(4*((c-r+4)%4)+r) -: 8]);
         end
      end
   end

   assign w_keyed = w_subbed ^ i_round_key;

   // InvMixColumns: row r of the circulant matrix is {0e,0b,0d,09} rotated by r.
   always_comb begin
      logic [7:0] w_acc;
      logic [7:0] w_coef;
      w_mixed = '0;
      w_acc   = 8'h00;
      w_coef  = 8'h00;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            w_acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
               case ((j - r + 4) % 4)
                  0:       w_coef = 8'h0e;
                  1:       w_coef = 8'h0b;
                  2:       w_coef = 8'h0d;
                  default: w_coef = 8'h09;
               endcase
               w_acc = w_acc ^ gmul(w_coef, w_keyed[127-8*(4*c+j) -: 8]);
            end
            w_mixed[127-8*(4*c+r) -: 8] = w_acc;
         end
      end
   end

   assign o_state = i_last_round ? w_keyed : w_mixed;

endmodule
`default_nettype wire

// File: rtl/aes_inv_cipher_iter.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_cipher_iter
//  Description : Iterative AES inverse cipher, one round per clock, for
//                128/192/256-bit keys using an externally held key schedule.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_inv_cipher_iter
   import aes_pkg::*;
#(
   parameter int Nk = 4,
   parameter int Nr = Nk + 6
)(
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] k_sch [0:Nr],
   input  logic         load,
   input  logic [127:0] ct,
   output logic         ready,
   output logic [127:0] pt,
   output logic         valid
);

   if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
      $error("aes_inv_cipher_iter: Nk must be 4, 6 or 8");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_FINAL = 2'd2,
      S_DONE  = 2'd3
   } fsm_t;

   localparam logic [3:0] c_round_start = 4'(Nr - 1);

   fsm_t       r_fsm;
   fsm_t       w_fsm_nxt;
   logic [3:0] r_round;
   aes_state_t r_state;
   aes_state_t r_pt;
   aes_state_t w_round_key;
   aes_state_t w_round_out;
   logic       w_ready;
   logic       w_valid;
   logic       w_last;

   // In FINAL the counter has reached 0, so the same lookup yields key 0.
   assign w_round_key = k_sch[r_round];

   aes_inv_round u_round (
      .i_state      (r_state),
      .i_round_key  (w_round_key),
      .i_last_round (w_last),
      .o_state      (w_round_out)
   );

   // State register for the control FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_fsm <= S_IDLE;
      else     r_fsm <= w_fsm_nxt;
   end

   // Next-state and handshake decode; DONE lasts one cycle so valid is a pulse.
   always_comb begin
      w_fsm_nxt = r_fsm;
      w_ready   = 1'b0;
      w_valid   = 1'b0;
      w_last    = 1'b0;
      case (r_fsm)
         S_IDLE: begin
            w_ready = 1'b1;
            if (load) w_fsm_nxt = S_ROUND;
         end
         S_ROUND: begin
            if (r_round == 4'd1) w_fsm_nxt = S_FINAL;
         end
         S_FINAL: begin
            w_last    = 1'b1;
            w_fsm_nxt = S_DONE;
         end
         S_DONE: begin
            w_ready   = 1'b1;
            w_valid   = 1'b1;
            w_fsm_nxt = load ? S_ROUND : S_IDLE;
         end
         default: w_fsm_nxt = S_IDLE;
      endcase
   end

   // Datapath: initial key whitening on accept, one round per ROUND cycle,
   // result captured into the output register on FINAL.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= '0;
         r_round <= 4'd0;
         r_pt    <= '0;
      end else begin
         if (w_ready && load) begin
            r_state <= ct ^ k_sch[Nr];
            r_round <= c_round_start;
         end else if (r_fsm == S_ROUND) begin
            r_state <= w_round_out;
            r_round <= r_round - 4'd1;
         end
         if (r_fsm == S_FINAL) r_pt <= w_round_out;
      end
   end

   assign ready = w_ready;
   assign valid = w_valid;
   assign pt    = r_pt;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_inv_cipher_iter
//  Description : Scoreboard bench for aes_inv_cipher_iter with FIPS-197
//                vectors for Nk = 4, 6 and 8.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_inv_cipher_iter;

   typedef struct {
      int unsigned cyc;
      logic [127:0] pt;
   } exp_t;

   localparam logic [127:0] c_pt_c   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] c_ct_c1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] c_ct_c2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] c_ct_c3  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] c_ct_b   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] c_pt_b   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [255:0] c_key_c1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] c_key_c2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] c_key_c3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] c_key_b  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

   logic        clk = 1'b0;
   logic        rst;
   int unsigned cyc = 0;

   always #5 clk = ~clk;

   // Cycle number used to time-stamp expected results.
   always @(posedge clk) cyc <= cyc + 1;

   logic         load4, load6, load8;
   logic [127:0] ct4, ct6, ct8;
   logic         ready4, ready6, ready8;
   logic [127:0] pt4, pt6, pt8;
   logic         valid4, valid6, valid8;
   logic [127:0] k4 [0:10];
   logic [127:0] k6 [0:12];
   logic [127:0] k8 [0:14];
   logic [127:0] rk_a [0:14];
   logic [127:0] rk_b [0:14];
   logic [127:0] rk_6 [0:14];
   logic [127:0] rk_8 [0:14];

   exp_t q4[$];
   exp_t q6[$];
   exp_t q8[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   aes_inv_cipher_iter #(.Nk(4)) u_dut4 (
      .clk(clk), .rst(rst), .k_sch(k4), .load(load4), .ct(ct4),
      .ready(ready4), .pt(pt4), .valid(valid4)
   );
   aes_inv_cipher_iter #(.Nk(6)) u_dut6 (
      .clk(clk), .rst(rst), .k_sch(k6), .load(load6), .ct(ct6),
      .ready(ready6), .pt(pt6), .valid(valid6)
   );
   aes_inv_cipher_iter #(.Nk(8)) u_dut8 (
      .clk(clk), .rst(rst), .k_sch(k8), .load(load8), .ct(ct8),
      .ready(ready8), .pt(pt8), .valid(valid8)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference GF(2^8) arithmetic and forward S-box for the key schedule.
   function automatic logic [7:0] tb_xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = tb_xtime(sh);
      end
      return acc;
   endfunction

   function automatic logic [7:0] tb_sbox(input logic [7:0] x);
      logic [7:0] inv;
      logic [7:0] rot;
      logic [7:0] s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
         if (tb_gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      s   = inv ^ 8'h63;
      rot = inv;
      for (int k = 0; k < 4; k++) begin
         rot = {rot[6:0], rot[7]};
         s   = s ^ rot;
      end
      return s;
   endfunction

   function automatic logic [31:0] tb_subword(input logic [31:0] t);
      return {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])};
   endfunction

   task automatic key_expand(input logic [255:0] key, input int nk, output logic [127:0] rk [0:14]);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rc;
      int          nr;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < 60; i++) w[i] = 32'h0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = tb_subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = tb_xtime(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = tb_subword(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int j = 0; j < 15; j++) rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
   endtask

   // Present a block and record the result due Nr+1 cycles later.
   task automatic issue(input int id, input logic [127:0] c, input logic [127:0] p);
      exp_t e;
      e.pt = p;
      case (id)
         0: begin chk("ready4_at_load", {127'h0, ready4}, 128'h1); load4 = 1'b1; ct4 = c; e.cyc = cyc + 11; q4.push_back(e); end
         1: begin chk("ready6_at_load", {127'h0, ready6}, 128'h1); load6 = 1'b1; ct6 = c; e.cyc = cyc + 13; q6.push_back(e); end
         default: begin chk("ready8_at_load", {127'h0, ready8}, 128'h1); load8 = 1'b1; ct8 = c; e.cyc = cyc + 15; q8.push_back(e); end
      endcase
   endtask

   task automatic mon(input int id, input logic [127:0] p);
      exp_t e;
      logic got;
      got = 1'b0;
      case (id)
         0: if (q4.size() > 0) begin e = q4.pop_front(); got = 1'b1; end
         1: if (q6.size() > 0) begin e = q6.pop_front(); got = 1'b1; end
         default: if (q8.size() > 0) begin e = q8.pop_front(); got = 1'b1; end
      endcase
      if (!got) begin
         n_checks++;
         $display("FAIL unexpected_valid dut%0d: valid=1 at cycle %0d, expected no result", id, cyc);
      end else begin
         chk($sformatf("pt_dut%0d", id), p, e.pt);
         chk($sformatf("latency_dut%0d", id), 128'(cyc), 128'(e.cyc));
      end
   endtask

   // Monitor: sample just after each rising edge and score every valid pulse.
   always @(posedge clk) begin
      #1;
      if (valid4) mon(0, pt4);
      if (valid6) mon(1, pt6);
      if (valid8) mon(2, pt8);
   end

   task automatic wait_drain(input int n);
      for (int i = 0; i < n; i++) begin
         if (q4.size() == 0 && q6.size() == 0 && q8.size() == 0) break;
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1;
      load4 = 1'b0; load6 = 1'b0; load8 = 1'b0;
      ct4 = '0; ct6 = '0; ct8 = '0;
      key_expand(c_key_c1, 4, rk_a);
      key_expand(c_key_b,  4, rk_b);
      key_expand(c_key_c2, 6, rk_6);
      key_expand(c_key_c3, 8, rk_8);
      for (int i = 0; i <= 10; i++) k4[i] = rk_a[i];
      for (int i = 0; i <= 12; i++) k6[i] = rk_6[i];
      for (int i = 0; i <= 14; i++) k8[i] = rk_8[i];

      repeat (3) @(negedge clk);
      chk("rst_ready4", {127'h0, ready4}, 128'h1);
      chk("rst_valid4", {127'h0, valid4}, 128'h0);
      chk("rst_pt4", pt4, 128'h0);
      chk("rst_pt8", pt8, 128'h0);
      rst = 1'b0;
      @(negedge clk);

      // All three key sizes at once.
      issue(0, c_ct_c1, c_pt_c);
      issue(1, c_ct_c2, c_pt_c);
      issue(2, c_ct_c3, c_pt_c);
      @(negedge clk);
      load4 = 1'b0; load6 = 1'b0; load8 = 1'b0;
      chk("busy_ready4", {127'h0, ready4}, 128'h0);
      wait_drain(40);
      @(negedge clk);
      chk("done_to_idle_ready8", {127'h0, ready8}, 128'h1);
      chk("done_to_idle_valid8", {127'h0, valid8}, 128'h0);

      // Back-to-back: second block (new key) loaded in the DONE cycle.
      issue(0, c_ct_c1, c_pt_c);
      @(negedge clk);
      load4 = 1'b0;
      for (int i = 0; i < 20 && !valid4; i++) @(negedge clk);
      chk("b2b_first_valid", {127'h0, valid4}, 128'h1);
      for (int i = 0; i <= 10; i++) k4[i] = rk_b[i];
      issue(0, c_ct_b, c_pt_b);
      @(negedge clk);
      load4 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("b2b_pt_hold", pt4, c_pt_c);
         @(negedge clk);
      end
      wait_drain(20);
      @(negedge clk);

      // Loads while busy at cycles 3 and 7 must be ignored.
      for (int i = 0; i <= 10; i++) k4[i] = rk_a[i];
      issue(0, c_ct_c1, c_pt_c);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         load4 = (i == 3 || i == 7);
         if (load4) begin
            chk("ignored_load_ready", {127'h0, ready4}, 128'h0);
            ct4 = 128'hdeadbeef_cafef00d_01234567_89abcdef;
         end
      end
      load4 = 1'b0;
      wait_drain(20);
      repeat (4) @(negedge clk);

      // Reset at cycle 5 of an operation aborts it without a result.
      issue(0, c_ct_c1, c_pt_c);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         load4 = 1'b0;
      end
      rst = 1'b1;
      q4.delete();
      @(negedge clk);
      chk("abort_pt", pt4, 128'h0);
      chk("abort_ready", {127'h0, ready4}, 128'h1);
      chk("abort_valid", {127'h0, valid4}, 128'h0);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      chk("abort_idle_ready", {127'h0, ready4}, 128'h1);
      chk("abort_pt_after", pt4, 128'h0);
      issue(0, c_ct_c1, c_pt_c);
      @(negedge clk);
      load4 = 1'b0;
      wait_drain(30);
      repeat (3) @(negedge clk);

      // Any result still owed by the DUT never arrived.
      while (q4.size() > 0) begin
         void'(q4.pop_front());
         n_checks++;
         $display("FAIL missing_valid dut0: expected result never presented");
      end
      while (q6.size() > 0) begin
         void'(q6.pop_front());
         n_checks++;
         $display("FAIL missing_valid dut1: expected result never presented");
      end
      while (q8.size() > 0) begin
         void'(q8.pop_front());
         n_checks++;
         $display("FAIL missing_valid dut2: expected result never presented");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
